bp_be_dcache_arbiter: RTL

Owns the single request port of `bp_be_dcache` and shares it between two requesters: the memory pipe (default owner) and the page-table walker (PTW, lock owner). It tracks which requester issued each access in the dcache's two-stage pipeline. It uses that to steer the tag-stage ptag/uncached inputs from the correct source and route the response valid back to the issuer. Ownership changes only after in-flight accesses drain, so PTW walks never interleave with pipe accesses.

---
 rtl/bp_be_dcache_arbiter_pkg.sv | 30 +++
 rtl/bp_be_dcache_arbiter_if.sv | 17 +
 rtl/bp_be_dcache_arb_tracker.sv | 39 +++
 rtl/bp_be_dcache_arbiter.sv | 113 +++++++++++
 4 files changed

// File: rtl/bp_be_dcache_arbiter_pkg.sv
// Shared types for the dcache request-port arbiter: FSM states, requester
// owner encoding and the in-flight tracker entry.
package bp_be_pkg;

  typedef enum logic [1:0] {
    E_PIPE          = 2'd0,
    E_DRAIN_TO_PTW  = 2'd1,
    E_PTW           = 2'd2,
    E_DRAIN_TO_PIPE = 2'd3
  } bp_be_dcache_arb_state_e;

  typedef enum logic {
    e_arb_pipe = 1'b0,
    e_arb_ptw  = 1'b1
  } bp_be_dcache_arb_owner_e;

  typedef struct packed {
    logic                    v;
    bp_be_dcache_arb_owner_e owner;
    logic                    poisoned;
  } bp_be_dcache_arb_entry_s;

  // A flush only ever poisons live pipe-owned work.
  function automatic logic arb_flush_hits(input logic v,
                                          input bp_be_dcache_arb_owner_e owner,
                                          input logic flush);
    return v & flush & (owner == e_arb_pipe);
  endfunction

endpackage

// File: rtl/bp_be_dcache_arbiter_if.sv
// Link between the arbiter FSM/mux and its in-flight tracker.
// Handshake: an access is recorded whenever acc_v is high; there is no back-pressure.
interface bp_be_dcache_arbiter_if;
  import bp_be_pkg::*;

  logic                    acc_v;
  bp_be_dcache_arb_owner_e acc_owner;
  logic                    flush;
  bp_be_dcache_arb_entry_s s1;
  bp_be_dcache_arb_entry_s s2;
  logic                    empty;

  modport master (output acc_v, output acc_owner, output flush,
                  input s1, input s2, input empty);
  modport slave  (input acc_v, input acc_owner, input flush,
                  output s1, output s2, output empty);
endinterface

// File: rtl/bp_be_dcache_arb_tracker.sv
// Two-entry shift register mirroring the dcache's two pipeline stages.
// Exposed s1/s2 already include poison from a flush in the current cycle.
module bp_be_dcache_arb_tracker
  import bp_be_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  bp_be_dcache_arbiter_if.slave   trk
);

  bp_be_dcache_arb_entry_s r_s1, r_s2;
  bp_be_dcache_arb_entry_s w_s1, w_s2, w_new;

  always_comb begin
    w_s1          = r_s1;
    w_s1.poisoned = r_s1.poisoned | arb_flush_hits(r_s1.v, r_s1.owner, trk.flush);
    w_s2          = r_s2;
    w_s2.poisoned = r_s2.poisoned | arb_flush_hits(r_s2.v, r_s2.owner, trk.flush);
    w_new.v        = trk.acc_v;
    w_new.owner    = trk.acc_owner;
    w_new.poisoned = arb_flush_hits(trk.acc_v, trk.acc_owner, trk.flush);
  end

  // s2 retires every cycle regardless of hit/miss; misses are replayed upstream.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= w_new;
      r_s2 <= w_s1;
    end
  end

  assign trk.s1    = w_s1;
  assign trk.s2    = w_s2;
  assign trk.empty = ~r_s1.v & ~r_s2.v;

endmodule

// File: rtl/bp_be_dcache_arbiter.sv
// Shares the single dcache request port between the memory pipe and the PTW,
// draining in-flight accesses before every ownership change.
module bp_be_dcache_arbiter
  import bp_be_pkg::*;
#(
  parameter int pkt_width_p  = 81,
  parameter int ptag_width_p = 28
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    flush_i,

  input  logic                    pipe_pkt_v_i,
  input  logic [pkt_width_p-1:0]  pipe_pkt_i,
  output logic                    pipe_ready_o,
  input  logic [ptag_width_p-1:0] pipe_ptag_i,
  input  logic                    pipe_ptag_v_i,
  input  logic                    pipe_uncached_i,
  output logic                    pipe_v_o,

  input  logic                    ptw_req_i,
  output logic                    ptw_grant_o,
  input  logic                    ptw_done_i,
  input  logic                    ptw_pkt_v_i,
  input  logic [pkt_width_p-1:0]  ptw_pkt_i,
  output logic                    ptw_ready_o,
  input  logic [ptag_width_p-1:0] ptw_ptag_i,
  input  logic                    ptw_ptag_v_i,
  output logic                    ptw_v_o,

  output logic                    dcache_pkt_v_o,
  output logic [pkt_width_p-1:0]  dcache_pkt_o,
  input  logic                    dcache_ready_i,
  output logic [ptag_width_p-1:0] dcache_ptag_o,
  output logic                    dcache_ptag_v_o,
  output logic                    dcache_uncached_o,
  input  logic                    dcache_v_i,
  input  logic                    dcache_miss_i,

  output logic                    busy_o,
  output logic [1:0]              dbg_state_o
);

  bp_be_dcache_arb_state_e r_state, w_state_next;
  logic w_pipe_ready, w_ptw_ready, w_pipe_acc, w_ptw_acc;

  bp_be_dcache_arbiter_if trk_if ();

  bp_be_dcache_arb_tracker u_tracker (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .trk       (trk_if.slave)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_state <= E_PIPE;
    else            r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      E_PIPE:          if (ptw_req_i) w_state_next = E_DRAIN_TO_PTW;
      // A miss may still trigger a pipe replay, so hold off the grant.
      E_DRAIN_TO_PTW:  if (trk_if.empty & dcache_ready_i & ~dcache_miss_i)
                         w_state_next = E_PTW;
      E_PTW:           if (ptw_done_i) w_state_next = E_DRAIN_TO_PIPE;
      E_DRAIN_TO_PIPE: if (trk_if.empty & dcache_ready_i) w_state_next = E_PIPE;
      default:         w_state_next = E_PIPE;
    endcase
  end

  always_comb begin
    w_pipe_ready = (r_state == E_PIPE) & ~ptw_req_i & dcache_ready_i;
    w_ptw_ready  = (r_state == E_PTW) & dcache_ready_i;
    w_pipe_acc   = w_pipe_ready & pipe_pkt_v_i;
    w_ptw_acc    = w_ptw_ready & ptw_pkt_v_i;

    pipe_ready_o = w_pipe_ready;
    ptw_ready_o  = w_ptw_ready;
    ptw_grant_o  = (r_state == E_PTW);
    busy_o       = (r_state != E_PIPE);
    dbg_state_o  = r_state;

    dcache_pkt_v_o = w_pipe_acc | w_ptw_acc;
    dcache_pkt_o   = '0;
    if (w_pipe_ready)     dcache_pkt_o = pipe_pkt_i;
    else if (w_ptw_ready) dcache_pkt_o = ptw_pkt_i;

    dcache_ptag_o     = '0;
    dcache_ptag_v_o   = 1'b0;
    dcache_uncached_o = 1'b0;
    if (trk_if.s1.v) begin
      if (trk_if.s1.owner == e_arb_ptw) begin
        dcache_ptag_o   = ptw_ptag_i;
        dcache_ptag_v_o = ptw_ptag_v_i & ~trk_if.s1.poisoned;
      end else begin
        dcache_ptag_o     = pipe_ptag_i;
        dcache_ptag_v_o   = pipe_ptag_v_i & ~trk_if.s1.poisoned;
        dcache_uncached_o = pipe_uncached_i;
      end
    end

    pipe_v_o = dcache_v_i & trk_if.s2.v & (trk_if.s2.owner == e_arb_pipe)
             & ~trk_if.s2.poisoned;
    ptw_v_o  = dcache_v_i & trk_if.s2.v & (trk_if.s2.owner == e_arb_ptw);
  end

  assign trk_if.acc_v     = w_pipe_acc | w_ptw_acc;
  assign trk_if.acc_owner = w_ptw_acc ? e_arb_ptw : e_arb_pipe;
  assign trk_if.flush     = flush_i;

endmodule
